// File: rtl/hack_mem_pkg.sv
// hack_mem_pkg: shared address map and target-select encoding for the Hack data memory.
`default_nettype none

package hack_mem_pkg;

  localparam logic [15:0] KBD_ADDR   = 16'h6000;
  localparam logic [15:0] TIMER_ADDR = 16'h6001;
  localparam logic [15:0] LED_ADDR   = 16'h6002;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_KBD,
    SEL_TIMER,
    SEL_LED,
    SEL_NONE
  } sel_e;

  // Full 16-bit decode: anything outside the populated RAM and the three registers is a hole.
  function automatic sel_e decode_addr(input logic [15:0] addr, input int unsigned ram_words);
    sel_e sel;
    sel = SEL_NONE;
    if (32'(addr) < ram_words) sel = SEL_RAM;
    else if (addr == KBD_ADDR) sel = SEL_KBD;
    else if (addr == TIMER_ADDR) sel = SEL_TIMER;
    else if (addr == LED_ADDR) sel = SEL_LED;
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hack_ms_timer.sv
// hack_ms_timer: prescaled free-running 16-bit timer with a CPU load port.
`default_nettype none

module hack_ms_timer #(
  parameter int TICK_DIV = 25000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_en,
  input  logic [15:0] load_val,
  output logic [15:0] timer
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_d, presc_q;
  logic [15:0]   timer_d, timer_q;

  always_comb begin
    presc_d = presc_q + 1'b1;
    timer_d = timer_q;
    // A load restarts the millisecond period so the new value lasts a full tick.
    if (load_en) begin
      presc_d = '0;
      timer_d = load_val;
    end else if (presc_q == PRESC_LAST) begin
      presc_d = '0;
      timer_d = timer_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc_q <= '0;
      timer_q <= '0;
    end else begin
      presc_q <= presc_d;
      timer_q <= timer_d;
    end
  end

  assign timer = timer_q;

endmodule

`default_nettype wire

// File: rtl/hack_data_mem.sv
// hack_data_mem: Hack CPU data-memory responder (RAM, keyboard, timer, LED) with zero-wait reads.
`default_nettype none

module hack_data_mem
  import hack_mem_pkg::*;
#(
  parameter int RAM_WORDS = 16384,
  parameter int TICK_DIV  = 25000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] inM,
  input  logic [15:0] kbd_data,
  input  logic        kbd_valid,
  output logic        kbd_ready,
  output logic [15:0] led
);

  localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  logic [15:0]   ram_q [RAM_WORDS];
  logic [AW-1:0] ram_idx;
  sel_e          sel;
  logic          wr_ram, wr_kbd, wr_timer, wr_led;
  logic [15:0]   kbd_d, kbd_q;
  logic [15:0]   led_d, led_q;
  logic [15:0]   timer_val;

  assign sel      = decode_addr(addressM, RAM_WORDS);
  assign ram_idx  = addressM[AW-1:0];
  assign wr_ram   = writeM && (sel == SEL_RAM);
  assign wr_kbd   = writeM && (sel == SEL_KBD);
  assign wr_timer = writeM && (sel == SEL_TIMER);
  assign wr_led   = writeM && (sel == SEL_LED);

  hack_ms_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_en  (wr_timer),
    .load_val (outM),
    .timer    (timer_val)
  );

  always_comb begin
    // The CPU owns the register in a write cycle, so the front end must keep holding its code.
    kbd_ready = (kbd_q == 16'd0) && !wr_kbd;
    kbd_d     = kbd_q;
    if (wr_kbd) kbd_d = outM;
    else if (kbd_valid && kbd_ready) kbd_d = kbd_data;

    led_d = wr_led ? outM : led_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      kbd_q <= '0;
      led_q <= '0;
    end else begin
      kbd_q <= kbd_d;
      led_q <= led_d;
    end
  end

  // Contents survive reset; only the write itself is suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (reset_n && wr_ram) ram_q[ram_idx] <= outM;
  end

  always_comb begin
    inM = 16'd0;
    case (sel)
      SEL_RAM:   inM = ram_q[ram_idx];
      SEL_KBD:   inM = kbd_q;
      SEL_TIMER: inM = timer_val;
      SEL_LED:   inM = led_q;
      default:   inM = 16'd0;
    endcase
  end

  assign led = led_q;

endmodule

`default_nettype wire
